ascon_permutation: RTL and testbench

ASCON_PERMUTATION -- requirements
Module: ascon_permutation

---
 rtl/ascon_pkg.sv | 23 ++
 rtl/ascon_permutation_if.sv | 20 ++
 rtl/ascon_round.sv | 43 ++++
 rtl/ascon_permutation.sv | 95 +++++++++
 tb/tb_ascon_permutation.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon permutation: FSM encoding, state
// layout, rotation amounts and the round-constant / rotate helpers.
package ascon_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam int ROUNDS_MAX_DEF = 12;

  // Word k of the 320-bit state lives at index [k].
  typedef logic [4:0][63:0] state_t;

  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [7:0] round_const(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int r);
    return (x >> r) | (x << (64 - r));
  endfunction

endpackage

// File: rtl/ascon_permutation_if.sv
// Control/data bundle between the host (spi_subnode side) and the permutation.
interface ascon_permutation_if;
  logic        load;
  logic        start;
  logic [3:0]  num_rounds;
  logic [63:0] S_0_in, S_1_in, S_2_in, S_3_in, S_4_in;
  logic [63:0] S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg;
  logic        busy;
  logic        done;

  modport master (
    output load, start, num_rounds, S_0_in, S_1_in, S_2_in, S_3_in, S_4_in,
    input  S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg, busy, done
  );

  modport slave (
    input  load, start, num_rounds, S_0_in, S_1_in, S_2_in, S_3_in, S_4_in,
    output S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg, busy, done
  );
endinterface

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced 5-bit S-box,
// linear diffusion layer.
module ascon_round
  import ascon_pkg::*;
(
  input  state_t     s_i,
  input  logic [3:0] rnd_i,
  output state_t     s_o
);

  state_t x, t;

  always_comb begin
    x    = s_i;
    t    = '0;
    x[2] = x[2] ^ {56'd0, round_const(rnd_i)};

    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    t[0] = ~x[0] & x[1];
    t[1] = ~x[1] & x[2];
    t[2] = ~x[2] & x[3];
    t[3] = ~x[3] & x[4];
    t[4] = ~x[4] & x[0];
    x[0] = x[0] ^ t[1];
    x[1] = x[1] ^ t[2];
    x[2] = x[2] ^ t[3];
    x[3] = x[3] ^ t[4];
    x[4] = x[4] ^ t[0];
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];

    s_o[0] = x[0] ^ ror64(x[0], ROT_A[0]) ^ ror64(x[0], ROT_B[0]);
    s_o[1] = x[1] ^ ror64(x[1], ROT_A[1]) ^ ror64(x[1], ROT_B[1]);
    s_o[2] = x[2] ^ ror64(x[2], ROT_A[2]) ^ ror64(x[2], ROT_B[2]);
    s_o[3] = x[3] ^ ror64(x[3], ROT_A[3]) ^ ror64(x[3], ROT_B[3]);
    s_o[4] = x[4] ^ ror64(x[4], ROT_A[4]) ^ ror64(x[4], ROT_B[4]);
  end

endmodule

// File: rtl/ascon_permutation.sv
// Iterated Ascon permutation p^n with load/start control.
// ASCON_TWO_ROUNDS_EN: chain two rounds per RUN cycle (ceil(n/2) latency).
module ascon_permutation
  import ascon_pkg::*;
#(
  parameter int ROUNDS_MAX = ROUNDS_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  ascon_permutation_if.slave  bus
);

  localparam logic [3:0] RMAX = 4'(ROUNDS_MAX);

  fsm_t       st_q;
  state_t     s_q;
  logic [3:0] rnd_q, rem_q;
  logic       busy_q, done_q;

  state_t     s_in, rnd1_s, step_s;
  logic [3:0] n_eff, step;

  assign s_in  = {bus.S_4_in, bus.S_3_in, bus.S_2_in, bus.S_1_in, bus.S_0_in};
  assign n_eff = (bus.num_rounds > RMAX) ? RMAX : bus.num_rounds;

  ascon_round u_rnd0 (.s_i(s_q), .rnd_i(rnd_q), .s_o(rnd1_s));

`ifdef ASCON_TWO_ROUNDS_EN
  localparam logic [3:0] STEP_MAX = 4'd2;
  state_t rnd2_s;

  ascon_round u_rnd1 (.s_i(rnd1_s), .rnd_i(rnd_q + 4'd1), .s_o(rnd2_s));

  // An odd remainder finishes with a single round in the last cycle.
  assign step   = (rem_q >= 4'd2) ? 4'd2 : 4'd1;
  assign step_s = (rem_q >= 4'd2) ? rnd2_s : rnd1_s;
`else
  localparam logic [3:0] STEP_MAX = 4'd1;

  assign step   = 4'd1;
  assign step_s = rnd1_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      s_q    <= '0;
      rnd_q  <= '0;
      rem_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          if (bus.load) s_q <= s_in;
          if (bus.start) begin
            rem_q <= n_eff;
            rnd_q <= RMAX - n_eff;
            if (n_eff == 4'd0) begin
              st_q   <= DONE;
              done_q <= 1'b1;
            end else begin
              st_q   <= RUN;
              busy_q <= 1'b1;
            end
          end
        end
        RUN: begin
          s_q   <= step_s;
          rnd_q <= rnd_q + step;
          rem_q <= rem_q - step;
          if (rem_q <= STEP_MAX) begin
            st_q   <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          st_q   <= IDLE;
          done_q <= 1'b0;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign bus.S_0_reg = s_q[0];
  assign bus.S_1_reg = s_q[1];
  assign bus.S_2_reg = s_q[2];
  assign bus.S_3_reg = s_q[3];
  assign bus.S_4_reg = s_q[4];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_ascon_permutation.sv
// Scoreboard bench for ascon_permutation: S-box-table reference model,
// expected results queued at start, monitor checks every falling edge.
module tb_ascon_permutation;

  typedef logic [4:0][63:0] st_t;
  typedef struct { int done_cyc; st_t exp; } exp_t;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  logic clk;
  logic rst_n;
  ascon_permutation_if bus ();

  ascon_permutation dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  st_t  mstate = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ror(logic [63:0] x, int r);
    return (x >> r) | (x << (64 - r));
  endfunction

  // Reference round: S-box applied column-wise via lookup table.
  function automatic st_t ref_round(st_t s, int i);
    st_t        y;
    logic [4:0] idx, v;
    y    = '0;
    s[2] = s[2] ^ 64'((15 - i) * 16 + i);
    for (int j = 0; j < 64; j++) begin
      idx = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      v   = SBOX[idx];
      for (int k = 0; k < 5; k++) y[k][j] = v[4-k];
    end
    for (int k = 0; k < 5; k++) y[k] = y[k] ^ ror(y[k], RA[k]) ^ ror(y[k], RB[k]);
    return y;
  endfunction

  function automatic st_t ref_perm(st_t s, int n);
    int ne;
    ne = (n > 12) ? 12 : n;
    for (int i = 12 - ne; i < 12; i++) s = ref_round(s, i);
    return s;
  endfunction

  function automatic int ref_lat(int n);
    int ne;
    ne = (n > 12) ? 12 : n;
`ifdef ASCON_TWO_ROUNDS_EN
    return (ne + 1) / 2;
`else
    return ne;
`endif
  endfunction

  task automatic chk(string nm, logic [319:0] act, logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    st_t act;
    act = {bus.S_4_reg, bus.S_3_reg, bus.S_2_reg, bus.S_1_reg, bus.S_0_reg};
    if (q.size() != 0) begin
      if (cyc < q[0].done_cyc) begin
        chk("busy_run", 320'(bus.busy), 320'd1);
        chk("done_early", 320'(bus.done), 320'd0);
      end else begin
        chk("done_pulse", 320'(bus.done), 320'd1);
        chk("busy_in_done", 320'(bus.busy), 320'd0);
        chk("result", act, q[0].exp);
        void'(q.pop_front());
      end
    end else begin
      chk("busy_idle", 320'(bus.busy), 320'd0);
      chk("done_idle", 320'(bus.done), 320'd0);
      chk("state_hold", act, mstate);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(st_t d);
    bus.S_0_in = d[0]; bus.S_1_in = d[1]; bus.S_2_in = d[2];
    bus.S_3_in = d[3]; bus.S_4_in = d[4];
  endtask

  function automatic st_t rnd_state();
    st_t d;
    for (int k = 0; k < 5; k++) d[k] = {$urandom, $urandom};
    return d;
  endfunction

  // One IDLE-cycle operation; model updated right after the sampling edge.
  task automatic op(input bit ld, input st_t d, input bit st, input int n);
    exp_t e;
    bus.load = ld; bus.start = st; bus.num_rounds = 4'(n);
    drive_in(d);
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    if (ld) mstate = d;
    if (st) begin
      e.exp      = ref_perm(mstate, n);
      e.done_cyc = cyc + ref_lat(n);
      mstate     = e.exp;
      q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 64 && q.size() != 0; k++) tick();
    if (q.size() != 0) begin
      $display("FAIL wait_idle done never arrived cyc=%0d", cyc);
      $fatal(1, "timeout");
    end
  endtask

  initial begin
    st_t pat;
    rst_n = 1'b0;
    bus.load = 1'b0; bus.start = 1'b0; bus.num_rounds = '0;
    drive_in('0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    op(1'b1, '0, 1'b0, 0);
    op(1'b0, '0, 1'b1, 12);
    wait_idle();

    pat = {5{64'h0123456789ABCDEF}};
    op(1'b1, pat, 1'b0, 0);
    op(1'b0, '0, 1'b1, 6);
    wait_idle();

    op(1'b0, '0, 1'b1, 0);
    wait_idle();
    op(1'b0, '0, 1'b1, 15);
    wait_idle();

    op(1'b1, rnd_state(), 1'b1, 7);
    wait_idle();

    // load/start pulsed mid-run must be ignored
    op(1'b0, '0, 1'b1, 8);
    tick(); tick();
    bus.load = 1'b1; bus.start = 1'b1; bus.num_rounds = 4'd2;
    drive_in(rnd_state());
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    wait_idle();

    // asynchronous reset in the middle of a run
    op(1'b0, '0, 1'b1, 12);
    repeat (4) tick();
    rst_n  = 1'b0;
    q.delete();
    mstate = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    op(1'b1, rnd_state(), 1'b0, 0);
    op(1'b0, '0, 1'b1, 12);
    wait_idle();

    for (int it = 0; it < 20; it++) begin
      int  n;
      bit  ld, tog;
      n   = $urandom_range(0, 15);
      ld  = 1'($urandom_range(0, 1));
      tog = 1'($urandom_range(0, 1));
      if (ld && !tog) op(1'b1, rnd_state(), 1'b0, 0);
      op(ld && tog, rnd_state(), 1'b1, n);
      wait_idle();
      if ($urandom_range(0, 1) == 1) tick();
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
